// File: rtl/ddc_phase_sched.sv
// ddc_phase_sched: round-robin phase-word scheduler for one shared ddc_core.
// Per-channel {poff, pinc} words live in a shadow bank (written by cfg_*) and
// an active bank (read by the issue path). Shadow is copied to active
// atomically at frame boundaries. Optional macro DDC_SCHED_TAG_EN builds the
// LATENCY-deep channel-tag delay line that labels ddc_core output samples.
module ddc_phase_sched #(
  parameter int N_CH    = 4,
  parameter int LATENCY = 14,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [19:0]     cfg_pinc,
  input  logic [19:0]     cfg_poff,
  input  logic            commit_req,
  output logic            commit_ack,
  output logic            commit_pending,
  input  logic            run,
  output logic            phase_valid,
  output logic [48:0]     phase_data,
  output logic [CH_W-1:0] phase_ch,
  output logic [CH_W-1:0] ddc_ch,
  output logic            ddc_ch_valid
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] cnt, cnt_nxt;
  logic            issue;
  logic            boundary, do_commit;
  logic [39:0]     shadow [N_CH];
  logic [39:0]     active [N_CH];
  logic [39:0]     src;
  logic            resync;
  logic [N_CH-1:0] dirty, dirty_nxt;

  // Boundary detection: any pending cycle while idle, else the cycle showing the last channel.
  always_comb begin
    boundary  = (state == IDLE) ? commit_pending
                                : (phase_valid && (phase_ch == LAST_CH));
    do_commit = commit_pending && boundary;
    // A copy at this edge must already be visible to the word issued at this edge.
    src       = do_commit ? shadow[cnt] : active[cnt];
    resync    = do_commit | dirty[cnt];
  end

  // Next-state logic: STOP keeps issuing until the frame is complete (cnt back at 0).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          issue     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN, STOP: begin
        if (run) begin
          issue     = 1'b1;
          state_nxt = RUN;
        end else if (cnt != '0) begin
          issue     = 1'b1;
          state_nxt = STOP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) cnt_nxt = (cnt == LAST_CH) ? '0 : cnt + CH_W'(1);
  end

  // Dirty bits: all set on a commit, the issued channel's bit consumed by its issue.
  always_comb begin
    dirty_nxt = do_commit ? '1 : dirty;
    if (issue) dirty_nxt[cnt] = 1'b0;
  end

  // Control state and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      dirty          <= '1;
      phase_valid    <= 1'b0;
      phase_ch       <= '0;
      phase_data     <= '0;
      commit_ack     <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      dirty          <= dirty_nxt;
      phase_valid    <= issue;
      phase_ch       <= issue ? cnt : '0;
      phase_data     <= issue ? {resync, 4'b0, src[39:20], 4'b0, src[19:0]} : '0;
      commit_ack     <= do_commit;
      if (do_commit)       commit_pending <= 1'b0;
      else if (commit_req) commit_pending <= 1'b1;
    end
  end

  // Shadow writes and the atomic shadow-to-active copy; a write in the boundary cycle misses the copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (do_commit) begin
        for (int i = 0; i < N_CH; i++) active[i] <= shadow[i];
      end
      if (cfg_we && (int'(cfg_ch) < N_CH)) shadow[cfg_ch] <= {cfg_poff, cfg_pinc};
    end
  end

`ifdef DDC_SCHED_TAG_EN
  logic [CH_W:0] tag_p [LATENCY];

  // Tag delay line: shifts every cycle in every state so tags track core latency exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= {phase_valid, phase_ch};
      for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign {ddc_ch_valid, ddc_ch} = tag_p[LATENCY-1];
`else
  assign ddc_ch       = '0;
  assign ddc_ch_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ddc_phase_sched.sv
// Bench for ddc_phase_sched: directed scenarios plus randomized traffic, all
// compared every cycle against a channel/bank/frame-level reference model.
module tb_ddc_phase_sched;
  localparam int N_CH    = 4;
  localparam int LATENCY = 14;
  localparam int CH_W    = $clog2(N_CH);

  logic            clk = 1'b0;
  logic            rst_n, cfg_we, commit_req, run;
  logic [CH_W-1:0] cfg_ch;
  logic [19:0]     cfg_pinc, cfg_poff;
  logic            commit_ack, commit_pending, phase_valid, ddc_ch_valid;
  logic [48:0]     phase_data;
  logic [CH_W-1:0] phase_ch, ddc_ch;

  ddc_phase_sched #(.N_CH(N_CH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_pinc(cfg_pinc), .cfg_poff(cfg_poff), .commit_req(commit_req),
    .commit_ack(commit_ack), .commit_pending(commit_pending), .run(run),
    .phase_valid(phase_valid), .phase_data(phase_data), .phase_ch(phase_ch),
    .ddc_ch(ddc_ch), .ddc_ch_valid(ddc_ch_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: banks, dirty flags, pending commit, frame progress, tag history.
  logic [39:0] m_shadow [N_CH];
  logic [39:0] m_active [N_CH];
  bit          m_dirty  [N_CH];
  bit          m_pending, m_ack, m_valid, m_in_frame;
  int          m_ch, m_next, m_tag;
  logic [48:0] m_data;
  int          hist [$];

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
      m_dirty[i]  = 1'b1;
    end
    m_pending = 0; m_ack = 0; m_valid = 0; m_in_frame = 0;
    m_ch = 0; m_next = 0; m_data = '0; m_tag = 0;
    hist.delete();
    for (int i = 0; i < LATENCY - 1; i++) hist.push_back(0);
  endtask

  task automatic model_step();
    bit boundary, copy, go;
    int ch;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back((int'(m_valid) << CH_W) | m_ch);
    m_tag = hist.pop_front();
    boundary = m_in_frame ? (m_valid && m_ch == N_CH - 1) : m_pending;
    copy = m_pending && boundary;
    if (copy) begin
      for (int i = 0; i < N_CH; i++) begin
        m_active[i] = m_shadow[i];
        m_dirty[i]  = 1'b1;
      end
    end
    go = 0; ch = 0;
    if (!m_in_frame) begin
      if (run) go = 1;
    end else if (run || m_next != 0) begin
      go = 1; ch = m_next;
    end
    if (go) begin
      m_data = {m_dirty[ch], 4'b0, m_active[ch][39:20], 4'b0, m_active[ch][19:0]};
      m_dirty[ch] = 1'b0;
      m_valid = 1; m_ch = ch; m_next = (ch + 1) % N_CH; m_in_frame = 1;
    end else begin
      m_valid = 0; m_ch = 0; m_data = '0; m_next = 0; m_in_frame = 0;
    end
    if (cfg_we && cfg_ch < N_CH) m_shadow[cfg_ch] = {cfg_poff, cfg_pinc};
    m_ack = copy;
    if (copy) m_pending = 0;
    else if (commit_req) m_pending = 1;
  endtask

  task automatic compare_all();
    check("phase_valid", phase_valid, m_valid);
    check("phase_ch", phase_ch, m_ch);
    check("phase_data", phase_data, m_data);
    check("commit_ack", commit_ack, m_ack);
    check("commit_pending", commit_pending, m_pending);
`ifdef DDC_SCHED_TAG_EN
    check("ddc_tag", {ddc_ch_valid, ddc_ch}, m_tag);
`else
    check("ddc_tag_off", {ddc_ch_valid, ddc_ch}, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_ch(input int target);
    for (int k = 0; k < 2 * N_CH; k++) begin
      if (phase_valid && phase_ch == target) return;
      tick();
    end
    check("wait_ch", phase_ch, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; cfg_we = 0; cfg_ch = '0; cfg_pinc = '0; cfg_poff = '0;
    commit_req = 0; run = 0;
    model_reset();
    tick(); tick();
    check("rst_valid", phase_valid, 0);
    check("rst_data", phase_data, 0);
    check("rst_pending", commit_pending, 0);
    check("rst_ack", commit_ack, 0);
    rst_n = 1;

    // Load all channels, commit while idle, then run two frames.
    for (int c = 0; c < N_CH; c++) begin
      cfg_we = 1; cfg_ch = CH_W'(c); cfg_pinc = 20'(32'h100 * (c + 1)); cfg_poff = 20'($urandom);
      tick();
    end
    cfg_we = 0;
    commit_req = 1; tick(); commit_req = 0;
    check("s1_pending", commit_pending, 1);
    check("s1_ack_early", commit_ack, 0);
    tick();
    check("s1_ack", commit_ack, 1);
    run = 1;
    for (int i = 0; i < 2 * N_CH; i++) begin
      tick();
      check("s1_ch", phase_ch, i % N_CH);
      check("s1_pinc", phase_data[19:0], 32'h100 * (i % N_CH + 1));
      check("s1_resync", phase_data[48], i < N_CH);
    end

    // Commit requested mid-frame with a ch2 update.
    wait_ch(1);
    cfg_we = 1; cfg_ch = 2; cfg_pinc = 20'h555; commit_req = 1;
    tick();
    cfg_we = 0; commit_req = 0;
    check("s2_old", phase_data[19:0], 20'h300);
    tick(); tick();
    check("s2_rs0", phase_data[48], 1);
    tick(); tick();
    check("s2_ch2", phase_ch, 2);
    check("s2_pinc", phase_data[19:0], 20'h555);
    check("s2_rs2", phase_data[48], 1);

    // Write in the boundary cycle misses the first commit.
    commit_req = 1; tick(); commit_req = 0;
    cfg_we = 1; cfg_ch = 1; cfg_pinc = 20'h777;
    tick();
    cfg_we = 0;
    tick();
    check("s3_ch1_old", phase_data[19:0], 20'h200);
    commit_req = 1; tick(); commit_req = 0;
    tick(); tick(); tick();
    check("s3_ch1_new", phase_data[19:0], 20'h777);

    // Stop drains the frame; re-raising run during STOP leaves no gap.
    run = 0; tick();
    check("s4_drain2", phase_ch, 2);
    tick();
    check("s4_drain3", phase_ch, 3);
    tick();
    check("s4_idle", phase_valid, 0);
    run = 1; tick(); tick();
    run = 0; tick();
    run = 1; tick(); tick();
    check("s4_nogap", phase_valid, 1);
    wait_ch(3);
    run = 0; tick();
    check("s4_last", phase_valid, 0);

    // Reset mid-frame with a pending commit.
    run = 1; tick();
    commit_req = 1; tick(); commit_req = 0;
    rst_n = 0; tick();
    check("s5_valid", phase_valid, 0);
    check("s5_pending", commit_pending, 0);
    rst_n = 1;
    for (int i = 0; i < 2 * N_CH; i++) begin
      tick();
      check("s5_pinc", phase_data[19:0], 0);
      check("s5_resync", phase_data[48], i < N_CH);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cfg_we     = ($urandom % 4) == 0;
      cfg_ch     = CH_W'($urandom);
      cfg_pinc   = 20'($urandom);
      cfg_poff   = 20'($urandom);
      commit_req = ($urandom % 12) == 0;
      if (($urandom % 40) == 0) run = ~run;
      rst_n      = ($urandom % 600) != 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
